// File: rtl/soc_mtimer_pkg.sv
// soc_mtimer_pkg
// Shared definitions for the machine timer: register byte offsets, the
// 2-bit word indices decoded from i_addr[3:2], and a byte-enable merge helper.
package soc_mtimer_pkg;

    localparam logic [3:0] ADDR_MTIME_LO    = 4'h0;
    localparam logic [3:0] ADDR_MTIME_HI    = 4'h4;
    localparam logic [3:0] ADDR_MTIMECMP_LO = 4'h8;
    localparam logic [3:0] ADDR_MTIMECMP_HI = 4'hC;

    typedef enum logic [1:0] {
        REG_MTIME_LO    = ADDR_MTIME_LO[3:2],
        REG_MTIME_HI    = ADDR_MTIME_HI[3:2],
        REG_MTIMECMP_LO = ADDR_MTIMECMP_LO[3:2],
        REG_MTIMECMP_HI = ADDR_MTIMECMP_HI[3:2]
    } reg_idx_e;

    // Replace only the bytes of old_v whose enable bit is set.
    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/soc_mtimer_prescaler.sv
// soc_mtimer_prescaler
// Divides i_clk down to the mtime increment rate. The count runs
// 0..p_prescale-1 and o_tick is high in the cycle the count sits at its last
// value. i_halt freezes the count and suppresses the tick; i_clear forces the
// count back to 0 (used when software rewrites mtime).
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   i_halt   freeze count, no tick
//   i_clear  synchronous return of the count to 0
//   o_tick   one-cycle increment strobe for mtime
module soc_mtimer_prescaler #(
    parameter int unsigned p_prescale = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_halt,
    input  logic i_clear,
    output logic o_tick
);

    localparam logic [15:0] LP_LAST = 16'(p_prescale - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        at_last;

    assign at_last = (cnt_q == LP_LAST);
    assign o_tick  = at_last & ~i_halt;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (!i_halt) begin
            cnt_d = at_last ? 16'd0 : cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/soc_mtimer.sv
// soc_mtimer
// RISC-V style machine timer: 64-bit mtime counter advanced by a prescaler,
// 64-bit mtimecmp compare register and a level timer interrupt. Accessed
// through a simple single-cycle-request bus with a registered response.
//
// Ports:
//   i_clk, i_rst_n   clock and asynchronous active-low reset
//   i_halt           freeze prescaler and mtime
//   i_cs, i_we       access request pulse / write select
//   i_addr           byte offset, bits [3:2] select the register
//   i_wdata, i_be    write data and byte enables
//   o_rdata, o_ready registered read data / access completion
//   o_mtime          live mtime value
//   o_timer_irq      registered (mtime >= mtimecmp)
module soc_mtimer
    import soc_mtimer_pkg::*;
#(
    parameter int unsigned p_prescale     = 1,
    parameter logic [63:0] p_mtimecmp_rst = 64'hffffffff_ffffffff
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_halt,
    input  logic        i_cs,
    input  logic        i_we,
    input  logic [3:0]  i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_be,
    output logic [31:0] o_rdata,
    output logic        o_ready,
    output logic [63:0] o_mtime,
    output logic        o_timer_irq
);

    logic [63:0] mtime_q,    mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [31:0] rdata_q,    rdata_d;
    logic        ready_q;
    logic        irq_q;

    reg_idx_e    idx;
    logic        wr_en;
    logic        rd_en;
    logic        wr_mtime_lo;
    logic        wr_mtime_hi;
    logic        tick;
    logic        unused_addr;

    assign idx         = reg_idx_e'(i_addr[3:2]);
    assign wr_en       = i_cs & i_we;
    assign rd_en       = i_cs & ~i_we;
    assign wr_mtime_lo = wr_en & (idx == REG_MTIME_LO);
    assign wr_mtime_hi = wr_en & (idx == REG_MTIME_HI);
    assign unused_addr = ^i_addr[1:0];

    soc_mtimer_prescaler #(
        .p_prescale (p_prescale)
    ) u_prescaler (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_halt  (i_halt),
        .i_clear (wr_mtime_lo | wr_mtime_hi),
        .o_tick  (tick)
    );

    // A write to either mtime half wins over a coincident tick: the untouched
    // half holds, so no increment or carry leaks into that cycle.
    always_comb begin
        mtime_d = mtime_q;
        if (wr_mtime_lo) begin
            mtime_d[31:0] = be_merge(mtime_q[31:0], i_wdata, i_be);
        end else if (wr_mtime_hi) begin
            mtime_d[63:32] = be_merge(mtime_q[63:32], i_wdata, i_be);
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    always_comb begin
        mtimecmp_d = mtimecmp_q;
        if (wr_en && idx == REG_MTIMECMP_LO) begin
            mtimecmp_d[31:0] = be_merge(mtimecmp_q[31:0], i_wdata, i_be);
        end else if (wr_en && idx == REG_MTIMECMP_HI) begin
            mtimecmp_d[63:32] = be_merge(mtimecmp_q[63:32], i_wdata, i_be);
        end
    end

    // Read data is captured from the pre-edge register values and forced to 0
    // whenever no read completes, so o_rdata is 0 whenever o_ready is low.
    always_comb begin
        rdata_d = '0;
        if (rd_en) begin
            case (idx)
                REG_MTIME_LO:    rdata_d = mtime_q[31:0];
                REG_MTIME_HI:    rdata_d = mtime_q[63:32];
                REG_MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
                REG_MTIMECMP_HI: rdata_d = mtimecmp_q[63:32];
                default:         rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mtime_q    <= '0;
            mtimecmp_q <= p_mtimecmp_rst;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            rdata_q    <= rdata_d;
            ready_q    <= i_cs;
            irq_q      <= (mtime_q >= mtimecmp_q);
        end
    end

    assign o_mtime     = mtime_q;
    assign o_rdata     = rdata_q;
    assign o_ready     = ready_q;
    assign o_timer_irq = irq_q;

endmodule

// File: tb/tb_soc_mtimer.sv
// tb_soc_mtimer
// Directed bench for soc_mtimer. Two instances share clock and reset:
// dut_p1 (p_prescale = 1) for bus, wrap, compare and byte-enable cases,
// dut_p4 (p_prescale = 4) for prescaler rate and halt behaviour.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_soc_mtimer;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;

    logic        halt1, cs1, we1;
    logic [3:0]  addr1, be1;
    logic [31:0] wdata1, rdata1;
    logic        ready1, irq1;
    logic [63:0] mtime1;

    logic        halt4, cs4, we4;
    logic [3:0]  addr4, be4;
    logic [31:0] wdata4, rdata4;
    logic        ready4, irq4;
    logic [63:0] mtime4;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    soc_mtimer #(.p_prescale(1)) dut_p1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_halt(halt1), .i_cs(cs1), .i_we(we1),
        .i_addr(addr1), .i_wdata(wdata1), .i_be(be1), .o_rdata(rdata1),
        .o_ready(ready1), .o_mtime(mtime1), .o_timer_irq(irq1)
    );

    soc_mtimer #(.p_prescale(4)) dut_p4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_halt(halt4), .i_cs(cs4), .i_we(we4),
        .i_addr(addr4), .i_wdata(wdata4), .i_be(be4), .o_rdata(rdata4),
        .o_ready(ready4), .o_mtime(mtime4), .o_timer_irq(irq4)
    );

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one bus cycle at the current falling edge and advance to the next
    // falling edge (the response cycle). Signals stay driven until changed.
    task automatic drive1(input logic cs, input logic we, input logic [3:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
        cs1 = cs; we1 = we; addr1 = addr; wdata1 = wdata; be1 = be;
        @(negedge clk);
    endtask

    task automatic drive4(input logic cs, input logic we, input logic [3:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
        cs4 = cs; we4 = we; addr4 = addr; wdata4 = wdata; be4 = be;
        @(negedge clk);
    endtask

    initial begin
        halt1 = 1'b0; cs1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0; be1 = '0;
        halt4 = 1'b0; cs4 = 1'b0; we4 = 1'b0; addr4 = '0; wdata4 = '0; be4 = '0;

        #3;
        chk_val("rst_mtime1", mtime1, 64'd0);
        chk_val("rst_irq1",   irq1,   64'd0);
        chk_val("rst_ready1", ready1, 64'd0);
        chk_val("rst_rdata1", rdata1, 64'd0);
        chk_val("rst_mtime4", mtime4, 64'd0);

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Prescaler rate
        repeat (4) @(negedge clk);
        chk_val("p4_after4",  mtime4, 64'd1);
        chk_val("p1_after4",  mtime1, 64'd4);
        repeat (96) @(negedge clk);
        chk_val("p4_after100", mtime4, 64'd25);
        chk_val("p1_after100", mtime1, 64'd100);

        // Read latency: value as of the request cycle
        drive1(1'b1, 1'b0, 4'h0, 32'h0, 4'h0);
        chk_val("rd_lo_ready", ready1, 64'd1);
        chk_val("rd_lo_data",  rdata1, 64'd100);
        drive1(1'b1, 1'b0, 4'h4, 32'h0, 4'h0);
        chk_val("rd_hi_ready", ready1, 64'd1);
        chk_val("rd_hi_data",  rdata1, 64'd0);
        drive1(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        chk_val("idle_ready", ready1, 64'd0);
        chk_val("idle_rdata", rdata1, 64'd0);

        // Wrap from all-ones
        drive1(1'b1, 1'b1, 4'h0, 32'hffffffff, 4'hf);
        chk_val("wr_ready",   ready1, 64'd1);
        chk_val("wr_lo",      mtime1, 64'h00000000_ffffffff);
        drive1(1'b1, 1'b1, 4'h4, 32'hffffffff, 4'hf);
        chk_val("wr_allones", mtime1, 64'hffffffff_ffffffff);
        chk_val("irq_before", irq1,   64'd0);
        drive1(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        chk_val("wrap_zero",  mtime1, 64'd0);
        chk_val("irq_allones", irq1,  64'd1);
        @(negedge clk);
        chk_val("wrap_one",   mtime1, 64'd1);
        chk_val("irq_clear",  irq1,   64'd0);

        // Compare: mtimecmp = 0x10, mtime from 0
        drive1(1'b1, 1'b1, 4'h8, 32'h10, 4'hf);
        drive1(1'b1, 1'b1, 4'hC, 32'h0,  4'hf);
        drive1(1'b1, 1'b1, 4'h0, 32'h0,  4'hf);
        chk_val("cmp_mtime0", mtime1, 64'd0);
        chk_val("cmp_irq0",   irq1,   64'd0);
        drive1(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        repeat (15) @(negedge clk);
        chk_val("cmp_mtime10", mtime1, 64'h10);
        chk_val("cmp_irq_lo",  irq1,   64'd0);
        @(negedge clk);
        chk_val("cmp_irq_rise", irq1, 64'd1);
        drive1(1'b1, 1'b1, 4'h8, 32'h100, 4'hf);
        chk_val("cmp_irq_hold", irq1, 64'd1);
        drive1(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        chk_val("cmp_irq_fall", irq1, 64'd0);
        drive1(1'b1, 1'b0, 4'h8, 32'h0, 4'h0);
        chk_val("rd_cmp_lo", rdata1, 64'h100);
        drive1(1'b1, 1'b0, 4'hC, 32'h0, 4'h0);
        chk_val("rd_cmp_hi", rdata1, 64'h0);
        drive1(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);

        // Byte-enable write colliding with a tick, no carry
        drive1(1'b1, 1'b1, 4'h0, 32'hfffffffe, 4'hf);
        drive1(1'b1, 1'b1, 4'h0, 32'h00000005, 4'b0001);
        chk_val("be_lo_nocarry", mtime1, 64'h00000000_ffffff05);
        drive1(1'b1, 1'b1, 4'h4, 32'hABCDEF12, 4'b1010);
        chk_val("be_hi_hold_lo", mtime1, 64'hAB00EF00_ffffff05);
        drive1(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        chk_val("be_resume", mtime1, 64'hAB00EF00_ffffff06);

        // Carry across bit 31
        drive1(1'b1, 1'b1, 4'h4, 32'h0, 4'hf);
        drive1(1'b1, 1'b1, 4'h0, 32'hffffffff, 4'hf);
        chk_val("carry_pre", mtime1, 64'h00000000_ffffffff);
        drive1(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        chk_val("carry", mtime1, 64'h00000001_00000000);

        // Halt on the prescale-4 instance
        drive4(1'b1, 1'b1, 4'h0, 32'h7, 4'hf);
        chk_val("p4_wr_ready", ready4, 64'd1);
        chk_val("p4_wr",       mtime4, 64'd7);
        drive4(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        @(negedge clk);
        halt4 = 1'b1;
        repeat (50) @(negedge clk);
        chk_val("halt_mtime", mtime4, 64'd7);
        drive4(1'b1, 1'b0, 4'h0, 32'h0, 4'h0);
        chk_val("halt_rd_lo_ready", ready4, 64'd1);
        chk_val("halt_rd_lo",       rdata4, 64'd7);
        drive4(1'b1, 1'b0, 4'h4, 32'h0, 4'h0);
        chk_val("halt_rd_hi_ready", ready4, 64'd1);
        chk_val("halt_rd_hi",       rdata4, 64'd0);
        drive4(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        chk_val("halt_idle_ready", ready4, 64'd0);
        halt4 = 1'b0;
        @(negedge clk);
        chk_val("resume_hold", mtime4, 64'd7);
        @(negedge clk);
        chk_val("resume_tick", mtime4, 64'd8);

        // Reset in the middle of a read
        chk_val("pre_rst_irq", irq1, 64'd1);
        cs1 = 1'b1; we1 = 1'b0; addr1 = 4'h0;
        @(posedge clk);
        #2;
        chk_val("pre_rst_ready", ready1, 64'd1);
        rst_n = 1'b0;
        cs1   = 1'b0;
        #1;
        chk_val("rst_async_ready", ready1, 64'd0);
        chk_val("rst_async_rdata", rdata1, 64'd0);
        chk_val("rst_async_mtime", mtime1, 64'd0);
        chk_val("rst_async_irq",   irq1,   64'd0);
        chk_val("rst_async_mtime4", mtime4, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_val("no_stale_ready", ready1, 64'd0);
        drive1(1'b1, 1'b0, 4'h8, 32'h0, 4'h0);
        chk_val("rst_cmp_lo", rdata1, 64'hffffffff);
        drive1(1'b1, 1'b0, 4'hC, 32'h0, 4'h0);
        chk_val("rst_cmp_hi", rdata1, 64'hffffffff);
        drive1(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/soc_mtimer.md
SOC_MTIMER -- requirements
Module: soc_mtimer

Interface
REQ-001 SHALL have parameter p_prescale, default 1, clock cycles per mtime increment (legal range 1..65535).
REQ-002 SHALL have parameter p_mtimecmp_rst, default 64'hffffffff_ffffffff, reset value of mtimecmp.
REQ-003 SHALL have port i_clk  input  1  global clock, rising edge.
REQ-004 SHALL have port i_rst_n  input  1  global reset: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port i_halt  input  1  active-high freeze of prescaler and mtime (debug/sleep).
REQ-006 SHALL have port i_cs  input  1  bus access request, one-cycle pulse per access.
REQ-007 SHALL have port i_we  input  1  1 = write, 0 = read; sampled with i_cs.
REQ-008 SHALL have port i_addr  input  4  byte offset; only bits [3:2] are decoded.
REQ-009 SHALL have port i_wdata  input  32  write data.
REQ-010 SHALL have port i_be  input  4  write byte enables.
REQ-011 SHALL have port o_rdata  output  32  read data, valid while o_ready is high.
REQ-012 SHALL have port o_ready  output  1  access completion, one cycle after i_cs.
REQ-013 SHALL have port o_mtime  output  64  current mtime; feeds the SoC i_mtime input.
REQ-014 SHALL have port o_timer_irq  output  1  machine timer interrupt, level, active high.

Function
REQ-015 Register map: 0x0 mtime[31:0], 0x4 mtime[63:32], 0x8 mtimecmp[31:0], 0xC mtimecmp[63:32].
REQ-016 Prescaler counts 0..p_prescale-1; a tick is issued in the cycle the count equals p_prescale-1, then the count returns to 0.
REQ-017 With p_prescale = 1 a tick is issued every cycle.
REQ-018 On each tick mtime SHALL increment by 1 as a full 64-bit add (carry from bit 31 into bit 32 in the same cycle).
REQ-019 mtime at 64'hffffffff_ffffffff SHALL wrap to 0 on the next tick, with no other side effect.
REQ-020 While i_halt = 1 neither prescaler count nor mtime SHALL change; counting resumes from the held values when i_halt falls.
REQ-021 A write SHALL update only bytes whose i_be bit is set, in the cycle after i_cs; o_ready high that cycle.
REQ-022 A write to either mtime half in the same cycle as a tick SHALL take priority: the written half takes i_wdata, the other half is neither incremented nor carried into that cycle.
REQ-023 A write to mtime SHALL also reset the prescaler count to 0.
REQ-024 A read SHALL return the addressed register value as of the cycle i_cs was high, on o_rdata with o_ready one cycle later; o_rdata = 0 when o_ready = 0.
REQ-025 i_cs asserted on consecutive cycles SHALL be accepted every cycle (throughput 1 access/cycle).
REQ-026 o_timer_irq SHALL be registered: high in the cycle after (mtime >= mtimecmp), unsigned 64-bit compare, low in the cycle after the condition clears.
REQ-027 Writing mtimecmp above mtime SHALL deassert o_timer_irq within 2 cycles of i_cs.
REQ-028 o_mtime SHALL be the mtime register directly, no additional latency.

Reset
REQ-029 On i_rst_n low, asynchronously: mtime = 0, prescaler count = 0, mtimecmp = p_mtimecmp_rst, o_timer_irq = 0, o_ready = 0, o_rdata = 0.
REQ-030 An access in flight when reset asserts SHALL be discarded; no o_ready after reset release for it.
REQ-031 Counting SHALL begin on the first rising edge with i_rst_n high.

Structure
REQ-032 Register offsets (0x0, 0x4, 0x8, 0xC) and their 2-bit word indices SHALL live in package soc_mtimer_pkg.
REQ-033 The prescaler SHALL be a sub-module soc_mtimer_prescaler (inputs clock, reset, halt, clear; output tick).
REQ-034 The block SHALL contain no latches and no multi-cycle paths.

Verification
REQ-035 p_prescale = 4, reset released, no accesses -> mtime = 1 after 4 cycles, 25 after 100 cycles.
REQ-036 Write 0xffffffff to 0x0 and 0x4, p_prescale = 1 -> o_mtime = 0 one tick later; o_timer_irq stays 0 with mtimecmp at reset value until then and is 1 the cycle after mtime = all-ones.
REQ-037 Write mtimecmp = 0x0000_0000_0000_0010, p_prescale = 1, mtime from 0 -> o_timer_irq rises the cycle after mtime = 0x10; write 0x100 to 0x8 -> o_timer_irq falls within 2 cycles.
REQ-038 mtime = 0x0000_0000_ffff_fffe, tick and write 0x5 with i_be = 4'b0001 to 0x0 same cycle -> mtime = 0x0000_0000_ffff_ff05, no carry.
REQ-039 i_halt = 1 for 50 cycles mid-count -> mtime and prescaler unchanged; back-to-back reads of 0x0 and 0x4 return the held values with o_ready on consecutive cycles.
REQ-040 Assert i_rst_n low mid-read -> o_ready and o_rdata are 0 immediately, mtime = 0, mtimecmp = all-ones.
